neuron_voltage_bank: RTL
========================

NEURON_VOLTAGE_BANK -- requirements
Module: neuron_voltage_bank

Interface
REQ-001 Parameter DATA_W, default 16, width of each stored field (membrane voltage, voltage difference).
REQ-002 Parameter DEPTH, default 40, number of neuron entries.
REQ-003 Parameter ADDR_W, default 6, address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr_start  input  1  one-cycle pulse; starts the clear sweep.
REQ-007 busy  output  1  high while the clear sweep runs.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_vol, wr_diff  input  DATA_W each  post-update voltage and voltage difference to store.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  ADDR_W  read address.
REQ-013 rd_vol, rd_diff  output  DATA_W each  read data (registered).
REQ-014 rd_valid  output  1  high one cycle when rd_vol/rd_diff carry a new result.
REQ-015 addr_err  output  1  sticky flag: an out-of-range access occurred.

Function
REQ-016 Storage: DEPTH entries of {diff, vol}, 2*DATA_W bits; independent read and write ports usable in the same cycle.
REQ-017 Write: wr_en=1, wr_addr<DEPTH, FSM in READY -> entry updated at that edge.
REQ-018 Read latency 1: rd_en=1 in cycle N -> rd_vol/rd_diff valid and rd_valid=1 in cycle N+1; outputs hold their value while rd_valid=0.
REQ-019 Out-of-range (addr>=DEPTH) write SHALL be dropped; out-of-range read SHALL return zeros with rd_valid=1; either sets addr_err until reset.
REQ-020 FSM states: READY, CLEAR. Reset -> CLEAR (memory contents undefined after reset).
REQ-021 CLEAR: sweep pointer 0..DEPTH-1, one zero write per cycle; exactly DEPTH cycles; then READY. busy=1 throughout CLEAR.
REQ-022 clr_start in READY -> CLEAR next cycle, pointer restarts at 0; clr_start during CLEAR is ignored (no restart).
REQ-023 During CLEAR, wr_en and rd_en SHALL be ignored (no write, rd_valid stays 0, addr_err unaffected).
REQ-024 Simultaneous wr_en and rd_en to the same valid address: behaviour per REQ-031/REQ-032.
REQ-025 Simultaneous write/read to different addresses: both complete normally.

Reset
REQ-026 rst_n low SHALL asynchronously force: rd_vol=0, rd_diff=0, rd_valid=0, addr_err=0, busy=1, FSM=CLEAR, pointer=0.
REQ-027 Release of rst_n SHALL start the sweep on the first rising edge; busy falls DEPTH cycles later.
REQ-028 Reset asserted mid-sweep or mid-read SHALL abort it; the in-flight read produces no rd_valid.
REQ-029 The storage array itself SHALL NOT be reset (maps to block RAM); initialisation is by sweep only.

Configuration
REQ-030 Macro VOLTAGE_BANK_BYPASS_EN selects same-address read-during-write behaviour.
REQ-031 With VOLTAGE_BANK_BYPASS_EN defined: read returns the data being written in that cycle (write-first forwarding).
REQ-032 Without it: read returns the pre-write contents (read-first); no forwarding logic instantiated.

Structure
REQ-033 Shared package neuron_mem_pkg SHALL hold default DATA_W/DEPTH/ADDR_W constants, the FSM state enumeration, and the packed entry type {diff, vol}.
REQ-034 Sub-module voltage_bank_ram: simple dual-port synchronous RAM (1 write, 1 registered read port, no reset); sweep FSM, range checks and bypass live in the top.

Verification
REQ-035 Reset release -> busy=1 for exactly 40 cycles, then 0; read of any address 0..39 returns vol=0, diff=0.
REQ-036 Write addr 5 vol=0x1234 diff=0xFFF0, read addr 5 next cycle -> one cycle later rd_vol=0x1234, rd_diff=0xFFF0, rd_valid=1 for one cycle.
REQ-037 Addr 7 holds 0x0001/0x0002; same-cycle write 0x00AA/0x00BB and read addr 7 -> 0x00AA/0x00BB with bypass, 0x0001/0x0002 without.
REQ-038 Write addr 45 then read addr 45 -> no entry changes, read returns 0/0 with rd_valid=1, addr_err=1 and stays 1.
REQ-039 Fill entries, pulse clr_start, drive wr_en/rd_en during sweep -> no writes, no rd_valid; after 40 cycles all entries read 0.
REQ-040 Assert rst_n low at sweep cycle 20 -> outputs reset immediately; after release full 40-cycle sweep repeats.

Source files
------------

// File: rtl/neuron_mem_pkg.sv
// Shared definitions for the neuron voltage bank: default geometry,
// sweep FSM states and the stored entry layout {diff, vol}.
package neuron_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 40;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] diff;
        logic [DATA_W_DEF-1:0] vol;
    } entry_t;

    function automatic entry_t make_entry(input logic [DATA_W_DEF-1:0] vol,
                                          input logic [DATA_W_DEF-1:0] diff);
        entry_t e;
        e.vol  = vol;
        e.diff = diff;
        return e;
    endfunction

endpackage

// File: rtl/voltage_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module voltage_bank_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 40,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Read-first: a same-address read in the write cycle sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/neuron_voltage_bank.sv
// Neuron membrane voltage / difference store with a zeroing sweep after reset or clr_start.
// Optional macro VOLTAGE_BANK_BYPASS_EN enables write-first forwarding on same-address access.
module neuron_voltage_bank
    import neuron_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_vol,
    input  logic [DATA_W-1:0] wr_diff,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_vol,
    output logic [DATA_W-1:0] rd_diff,
    output logic              rd_valid,
    output logic              addr_err,
    output state_e            dbg_state
);

    localparam int                ENTRY_W   = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_zero_q, rd_zero_d;
    logic                addr_err_q, addr_err_d;

    logic                ready;
    logic                wr_oor, rd_oor;
    logic                wr_ok, rd_ok;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_wa;
    logic [ENTRY_W-1:0]  ram_wd;
    logic [ENTRY_W-1:0]  ram_rd;
    logic [ENTRY_W-1:0]  rd_entry;

    assign ready  = (state_q == ST_READY);
    assign wr_oor = (wr_addr > LAST_ADDR);
    assign rd_oor = (rd_addr > LAST_ADDR);
    assign wr_ok  = ready & wr_en & ~wr_oor;
    assign rd_ok  = ready & rd_en & ~rd_oor;

    // Read protocol: a request accepted in READY yields rd_valid for exactly one
    // cycle on the next cycle; rd_vol/rd_diff then hold until the next accepted read.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        case (state_q)
            ST_READY: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase

        busy_d     = (state_d == ST_CLEAR);
        rd_valid_d = ready & rd_en;
        rd_zero_d  = rd_zero_q;
        if (ready && rd_en) begin
            rd_zero_d = rd_oor;
        end
        addr_err_d = addr_err_q | (ready & ((wr_en & wr_oor) | (rd_en & rd_oor)));
    end

    // The sweep owns the RAM write port while clearing.
    assign ram_we = (state_q == ST_CLEAR) | wr_ok;
    assign ram_wa = ready ? wr_addr : ptr_q;
    assign ram_wd = ready ? {wr_diff, wr_vol} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
            addr_err_q <= addr_err_d;
        end
    end

    voltage_bank_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_wa),
        .wr_data (ram_wd),
        .rd_en   (rd_ok),
        .rd_addr (rd_addr),
        .rd_data (ram_rd)
    );

`ifdef VOLTAGE_BANK_BYPASS_EN
    logic               fwd_q, fwd_d;
    logic [ENTRY_W-1:0] fwd_data_q, fwd_data_d;

    always_comb begin
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        if (rd_ok) begin
            fwd_d      = wr_ok && (wr_addr == rd_addr);
            fwd_data_d = {wr_diff, wr_vol};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rd_entry = rd_zero_q ? '0 : (fwd_q ? fwd_data_q : ram_rd);
`else
    assign rd_entry = rd_zero_q ? '0 : ram_rd;
`endif

    assign rd_vol    = rd_entry[DATA_W-1:0];
    assign rd_diff   = rd_entry[ENTRY_W-1:DATA_W];
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
